fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_arb_pkg.sv | 15 +
 rtl/rr_priority_sel.sv | 30 +++
 rtl/fifo_wr_arbiter.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared types and default sizing for the fifo write arbiter
package fifo_arb_pkg;

  // Arbiter FSM: IDLE spends one cycle picking an owner, GRANT streams its burst
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  localparam int DEF_NUM_REQ    = 4;
  localparam int DEF_DATA_WIDTH = 16;
  localparam int DEF_DEPTH      = 18;
  localparam int DEF_BURST_LEN  = 4;

endpackage

// File: rtl/rr_priority_sel.sv
// rtl/rr_priority_sel.sv - round-robin pick of the first valid requester after last_owner
module rr_priority_sel #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     valid,
  input  logic [IDX_W-1:0] last_owner,
  output logic             any,
  output logic [IDX_W-1:0] sel_idx
);

  logic             found;
  logic [IDX_W-1:0] cand;

  // Scan last_owner+1 .. last_owner+N (mod N); the first valid candidate wins
  always_comb begin
    any     = |valid;
    sel_idx = '0;
    found   = 1'b0;
    cand    = '0;
    for (int k = 1; k <= N; k++) begin
      cand = IDX_W'((int'(last_owner) + k) % N);
      if (!found && valid[cand]) begin
        found   = 1'b1;
        sel_idx = cand;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - credit-based round-robin burst arbiter for one fifo_mem write port
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = DEF_NUM_REQ,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int BURST_LEN  = DEF_BURST_LEN
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          fifo_wr,
  output logic [DATA_WIDTH-1:0]         fifo_wdata,
  input  logic                          fifo_pop,
  input  logic                          fifo_full,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic [$clog2(DEPTH+1)-1:0]    credit_cnt,
  output logic                          credit_err
);

  localparam int IDX_W  = $clog2(NUM_REQ);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int BEAT_W = $clog2(BURST_LEN + 1);

  localparam logic [CNT_W-1:0]  CREDIT_MAX = CNT_W'(DEPTH);
  localparam logic [BEAT_W-1:0] LAST_BEAT  = BEAT_W'(BURST_LEN - 1);
  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_REQ - 1);

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [IDX_W-1:0]        last_owner_q, last_owner_d;
  logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0]        credit_q, credit_d;
  logic                    err_q, err_d;
  logic                    wr_q, wr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;

  logic                    rr_any;
  logic [IDX_W-1:0]        rr_sel;
  logic                    credit_avail;
  logic                    owner_valid;
  logic                    xfer;
  logic                    pop_overflow;
  logic [DATA_WIDTH-1:0]   data_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign data_arr[g] = req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_priority_sel #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_rr_sel (
    .valid      (req_valid),
    .last_owner (last_owner_q),
    .any        (rr_any),
    .sel_idx    (rr_sel)
  );

  assign credit_avail = (credit_q != '0);
  assign owner_valid  = req_valid[owner_q];
  assign xfer         = (state_q == GRANT) && credit_avail && owner_valid;
  assign pop_overflow = fifo_pop && (credit_q == CREDIT_MAX);

  // Only the owner is offered ready, and only while a FIFO slot is guaranteed
  always_comb begin
    req_ready = '0;
    if (state_q == GRANT && credit_avail) begin
      req_ready[owner_q] = 1'b1;
    end
  end

  // Arbitration and burst tracking; a dropped valid ends the burst early
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    beat_cnt_d   = beat_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (rr_any && credit_avail) begin
          state_d    = GRANT;
          owner_d    = rr_sel;
          beat_cnt_d = '0;
        end
      end
      GRANT: begin
        if (!owner_valid) begin
          state_d      = IDLE;
          last_owner_d = owner_q;
        end else if (xfer) begin
          beat_cnt_d = beat_cnt_q + BEAT_W'(1);
          if (beat_cnt_q == LAST_BEAT) begin
            state_d      = IDLE;
            last_owner_d = owner_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Write pipeline stage plus credit accounting and the sticky error flag
  always_comb begin
    wr_d     = xfer;
    wdata_d  = xfer ? data_arr[owner_q] : wdata_q;
    credit_d = credit_q;
    case ({xfer, fifo_pop})
      2'b10:   credit_d = credit_q - CNT_W'(1);
      2'b01:   if (credit_q != CREDIT_MAX) credit_d = credit_q + CNT_W'(1);
      default: credit_d = credit_q;
    endcase
    err_d = err_q | pop_overflow | (wr_q & fifo_full);
  end

  // State and output registers; reset also discards a write still in the pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      owner_q      <= '0;
      last_owner_q <= LAST_IDX;
      beat_cnt_q   <= '0;
      credit_q     <= CREDIT_MAX;
      err_q        <= 1'b0;
      wr_q         <= 1'b0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      beat_cnt_q   <= beat_cnt_d;
      credit_q     <= credit_d;
      err_q        <= err_d;
      wr_q         <= wr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign fifo_wr    = wr_q;
  assign fifo_wdata = wdata_q;
  assign grant_id   = owner_q;
  assign credit_cnt = credit_q;
  assign credit_err = err_q;

endmodule
